mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 95 +++++++++
 tb/tb_mux_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: four-requester round-robin arbiter feeding a single registered
// payload slot with a valid/ready handshake on the downstream side.
// A payload is captured when the slot is empty, or when the slot drains in the
// same cycle, so a steady stream moves one payload per cycle.
module mux_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            req_i,
    input  logic [4*DATA_W-1:0]   data_i,
    output logic [3:0]            gnt_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [1:0]            sel_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_reg;
    logic [1:0]          ptr_reg;
    logic [1:0]          sel_reg;
    logic [DATA_W-1:0]   data_reg;

    // Unpacked view of the packed payload bus, one lane per requester.
    logic [DATA_W-1:0]   lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The slot can take a new payload when empty or when it is being drained
    // this cycle; nothing is captured while reset is held.
    logic capture_en;
    assign capture_en = !rst_i && ((state_reg == IDLE) || ready_i);

    // Round-robin search: first requesting index at or above ptr, wrapping.
    logic       win_found;
    logic [1:0] win_idx;
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_reg + 2'(k);
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    logic do_capture;
    assign do_capture = capture_en && win_found;

    // Grant is combinational and only ever raised on an actual capture.
    always_comb begin
        gnt_o = 4'b0000;
        if (do_capture) begin
            gnt_o = 4'b0001 << win_idx;
        end
    end

    // Slot FSM: capture loads payload/index and advances the pointer;
    // a drain without a new capture empties the slot but keeps data/sel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            data_reg  <= '0;
        end else if (do_capture) begin
            state_reg <= HOLD;
            data_reg  <= lane[win_idx];
            sel_reg   <= win_idx;
            ptr_reg   <= win_idx + 2'd1;
        end else if ((state_reg == HOLD) && ready_i) begin
            state_reg <= IDLE;
        end
    end

    assign valid_o = (state_reg == HOLD);
    assign busy_o  = valid_o;
    assign data_o  = data_reg;
    assign sel_o   = sel_reg;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed testbench for mux_arbiter: each task drives one scenario and checks
// grants and the registered output slot against hand-computed values.
module tb_mux_arbiter;

    localparam int DATA_W = 8;

    logic                 clk;
    logic                 rst_i;
    logic [3:0]           req_i;
    logic [4*DATA_W-1:0]  data_i;
    logic [3:0]           gnt_o;
    logic                 valid_o;
    logic [DATA_W-1:0]    data_o;
    logic [1:0]           sel_o;
    logic                 ready_i;
    logic                 busy_o;

    int check_count = 0;
    int pass_count  = 0;

    mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 4'b0000;
        ready_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        req_i   = 4'b1111;
        ready_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        #1;
        check_count++;
        if (gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt_o);
        else pass_count++;
        step();
        check_count++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL reset_valid: got %b/%b want 0/0", valid_o, busy_o);
        else pass_count++;
        check_count++;
        if (data_o !== 8'h00 || sel_o !== 2'd0) $display("FAIL reset_data: got %h/%0d want 00/0", data_o, sel_o);
        else pass_count++;
        rst_i = 1'b0;
        req_i = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0100;
        data_i = '0;
        data_i[2*DATA_W +: DATA_W] = 8'hA5;
        ready_i = 1'b1;
        #1;
        check_count++;
        if (gnt_o !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt_o);
        else pass_count++;
        step();
        req_i = 4'b0000;
        $display("single: valid=%b data=%h sel=%0d", valid_o, data_o, sel_o);
        check_count++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5 || sel_o !== 2'd2)
            $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=a5 s=2", valid_o, data_o, sel_o);
        else pass_count++;
        step();
        check_count++;
        if (valid_o !== 1'b0 || data_o !== 8'hA5 || sel_o !== 2'd2)
            $display("FAIL single_drain: got v=%b d=%h s=%0d want v=0 d=a5 s=2", valid_o, data_o, sel_o);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_gnt;
        logic [1:0] exp_sel;
        do_reset();
        req_i = 4'b1111;
        data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_sel = 2'(k % 4);
            exp_gnt = 4'b0001 << exp_sel;
            #1;
            check_count++;
            if (gnt_o !== exp_gnt) $display("FAIL b2b_gnt%0d: got %b want %b", k, gnt_o, exp_gnt);
            else pass_count++;
            step();
            $display("b2b %0d: gnt->sel=%0d data=%h valid=%b", k, sel_o, data_o, valid_o);
            check_count++;
            if (valid_o !== 1'b1 || sel_o !== exp_sel || data_o !== (8'h10 + 8'(exp_sel)))
                $display("FAIL b2b_out%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         k, valid_o, sel_o, data_o, exp_sel, 8'h10 + 8'(exp_sel));
            else pass_count++;
        end
        req_i = 4'b0000;
        step();
        check_count++;
        if (valid_o !== 1'b0 || sel_o !== 2'd0) $display("FAIL b2b_drain: got v=%b s=%0d want v=0 s=0", valid_o, sel_o);
        else pass_count++;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_i = 4'b0001;
        data_i = '0;
        data_i[0 +: DATA_W] = 8'h3C;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        req_i = 4'b1111;
        data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 5; k++) begin
            #1;
            check_count++;
            if (gnt_o !== 4'b0000) $display("FAIL bp_gnt%0d: got %b want 0000", k, gnt_o);
            else pass_count++;
            step();
            check_count++;
            if (valid_o !== 1'b1 || data_o !== 8'h3C || sel_o !== 2'd0)
                $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d want v=1 d=3c s=0", k, valid_o, data_o, sel_o);
            else pass_count++;
        end
        ready_i = 1'b1;
        #1;
        check_count++;
        if (gnt_o !== 4'b0010) $display("FAIL bp_release_gnt: got %b want 0010", gnt_o);
        else pass_count++;
        step();
        $display("bp release: sel=%0d data=%h", sel_o, data_o);
        check_count++;
        if (valid_o !== 1'b1 || data_o !== 8'h22 || sel_o !== 2'd1)
            $display("FAIL bp_release_out: got v=%b d=%h s=%0d want v=1 d=22 s=1", valid_o, data_o, sel_o);
        else pass_count++;
        req_i = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_i = 4'b0100;
        data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        ready_i = 1'b1;
        step();
        req_i = 4'b0011;
        #1;
        check_count++;
        if (gnt_o !== 4'b0001) $display("FAIL wrap_gnt0: got %b want 0001", gnt_o);
        else pass_count++;
        step();
        check_count++;
        if (sel_o !== 2'd0 || data_o !== 8'hD0) $display("FAIL wrap_out0: got s=%0d d=%h want s=0 d=d0", sel_o, data_o);
        else pass_count++;
        check_count++;
        if (gnt_o !== 4'b0010) $display("FAIL wrap_gnt1: got %b want 0010", gnt_o);
        else pass_count++;
        step();
        check_count++;
        if (sel_o !== 2'd1 || data_o !== 8'hD1) $display("FAIL wrap_out1: got s=%0d d=%h want s=1 d=d1", sel_o, data_o);
        else pass_count++;
        req_i = 4'b0000;
        step();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        req_i = 4'b0010;
        data_i = {8'hE3, 8'hE2, 8'h55, 8'hE0};
        ready_i = 1'b1;
        step();
        check_count++;
        if (valid_o !== 1'b1 || sel_o !== 2'd1) $display("FAIL rh_setup: got v=%b s=%0d want v=1 s=1", valid_o, sel_o);
        else pass_count++;
        ready_i = 1'b0;
        rst_i = 1'b1;
        req_i = 4'b1010;
        #1;
        check_count++;
        if (gnt_o !== 4'b0000) $display("FAIL rh_gnt_in_reset: got %b want 0000", gnt_o);
        else pass_count++;
        step();
        rst_i = 1'b0;
        check_count++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || sel_o !== 2'd0)
            $display("FAIL rh_cleared: got v=%b d=%h s=%0d want v=0 d=00 s=0", valid_o, data_o, sel_o);
        else pass_count++;
        // ready_i stays 0: in IDLE it must not block the first capture.
        #1;
        check_count++;
        if (gnt_o !== 4'b0010) $display("FAIL rh_first_gnt: got %b want 0010", gnt_o);
        else pass_count++;
        step();
        check_count++;
        if (valid_o !== 1'b1 || sel_o !== 2'd1 || data_o !== 8'h55)
            $display("FAIL rh_first_out: got v=%b s=%0d d=%h want v=1 s=1 d=55", valid_o, sel_o, data_o);
        else pass_count++;
        req_i = 4'b0000;
        ready_i = 1'b1;
        step();
    endtask

    initial begin
        rst_i   = 1'b1;
        req_i   = 4'b0000;
        data_i  = '0;
        ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
